// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// imem_loader_if : framed byte stream in, instruction RAM write strobe out
// Revision 1.0 - initial release
// ============================================================================
interface imem_loader_if;
  logic [7:0]  ByteData;
  logic        ByteValid;
  logic        ByteReady;
  logic        Start;
  logic        WriteEnable;
  logic [63:0] WriteAddress;
  logic [31:0] WriteData;
  logic [15:0] LoadedWords;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  // master: byte source / supervisor; slave: the loader itself
  modport master (
    output ByteData, ByteValid, Start,
    input  ByteReady, WriteEnable, WriteAddress, WriteData,
    input  LoadedWords, CpuHold, Done, Error
  );
  modport slave (
    input  ByteData, ByteValid, Start,
    output ByteReady, WriteEnable, WriteAddress, WriteData,
    output LoadedWords, CpuHold, Done, Error
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : assembles little-endian words from a checksummed byte frame
//               and writes them to instruction RAM, holding the CPU meanwhile
// Revision 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          MAX_WORDS = 1024
) (
  input  logic         CLK,
  input  logic         nReset,
  imem_loader_if.slave bus
);

  localparam logic [7:0]  c_sync_byte = 8'hA5;
  localparam logic [15:0] c_max_words = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_CNT0  = 3'd1,
    S_CNT1  = 3'd2,
    S_DATA  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_count;
  logic [23:0] r_word;
  logic [1:0]  r_bidx;
  logic [7:0]  r_csum;
  logic        r_we;
  logic [63:0] r_addr;
  logic [31:0] r_data;
  logic [15:0] r_loaded;
  logic        r_done;
  logic        r_error;

  logic        w_ready;
  logic        w_accept;
  logic        w_word_done;
  logic        w_rearm;
  logic [15:0] w_count;
  logic        w_last;

  assign w_accept = bus.ByteValid && w_ready;
  assign w_count  = {bus.ByteData, r_count[7:0]};
  assign w_last   = (r_loaded + 16'd1) == r_count;

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b1;
    w_word_done = 1'b0;
    w_rearm     = 1'b0;
    case (r_state)
      S_SYNC: begin
        if (w_accept && bus.ByteData == c_sync_byte) w_next = S_CNT0;
      end
      S_CNT0: begin
        if (w_accept) w_next = S_CNT1;
      end
      S_CNT1: begin
        if (w_accept) begin
          if (w_count == 16'd0 || w_count > c_max_words) w_next = S_ERROR;
          else                                            w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && r_bidx == 2'd3) begin
          w_word_done = 1'b1;
          if (w_last) w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_accept) w_next = (bus.ByteData == r_csum) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        w_ready = 1'b0;
        if (bus.Start) begin
          w_next  = S_SYNC;
          w_rearm = 1'b1;
        end
      end
      default: begin
        w_ready = 1'b0;
        w_next  = S_SYNC;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      r_count  <= 16'd0;
      r_word   <= 24'd0;
      r_bidx   <= 2'd0;
      r_csum   <= 8'd0;
      r_we     <= 1'b0;
      r_addr   <= BASE_ADDR;
      r_data   <= 32'd0;
      r_loaded <= 16'd0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_we    <= w_word_done;
      r_done  <= (w_next == S_DONE);
      r_error <= (w_next == S_ERROR);
      if (w_rearm) begin
        r_loaded <= 16'd0;
        r_csum   <= 8'd0;
        r_bidx   <= 2'd0;
        r_addr   <= BASE_ADDR;
      end
      if (w_accept) begin
        case (r_state)
          S_CNT0: r_count[7:0]  <= bus.ByteData;
          S_CNT1: r_count[15:8] <= bus.ByteData;
          S_DATA: begin
            // Bytes enter at the top so the oldest ends up least significant
            r_word <= {bus.ByteData, r_word[23:8]};
            r_csum <= r_csum ^ bus.ByteData;
            r_bidx <= r_bidx + 2'd1;
            if (r_bidx == 2'd3) begin
              r_data   <= {bus.ByteData, r_word};
              r_addr   <= BASE_ADDR + {46'd0, r_loaded, 2'b00};
              r_loaded <= r_loaded + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ByteReady    = w_ready;
  assign bus.WriteEnable  = r_we;
  assign bus.WriteAddress = r_addr;
  assign bus.WriteData    = r_data;
  assign bus.LoadedWords  = r_loaded;
  assign bus.CpuHold      = (r_state != S_DONE);
  assign bus.Done         = r_done;
  assign bus.Error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader : directed and random frames checked against a frame model
// Revision 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam logic [63:0] c_base      = 64'h0;
  localparam int          c_max_words = 1024;

  logic CLK;
  logic nReset;
  imem_loader_if bus ();

  imem_loader #(.BASE_ADDR(c_base), .MAX_WORDS(c_max_words)) dut (
    .CLK    (CLK),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [95:0] got[$];
  logic [31:0] frame_words[$];

  always @(negedge CLK) begin
    if (bus.WriteEnable === 1'b1) got.push_back({bus.WriteAddress, bus.WriteData});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    int tmo;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (g) begin
      @(negedge CLK);
      bus.ByteValid = 1'b0;
      bus.ByteData  = 8'($urandom);
    end
    @(negedge CLK);
    bus.ByteData  = b;
    bus.ByteValid = 1'b1;
    tmo = 0;
    while (bus.ByteReady !== 1'b1 && tmo < 50) begin
      @(negedge CLK);
      tmo++;
    end
    check("ready_wait", 64'(tmo < 50), 64'd1);
    @(posedge CLK);
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    bus.ByteValid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    bus.Start = 1'b1;
    @(negedge CLK);
    bus.Start = 1'b0;
    check("rearm_done",   64'(bus.Done),         64'd0);
    check("rearm_error",  64'(bus.Error),        64'd0);
    check("rearm_hold",   64'(bus.CpuHold),      64'd1);
    check("rearm_ready",  64'(bus.ByteReady),    64'd1);
    check("rearm_loaded", 64'(bus.LoadedWords),  64'd0);
    check("rearm_addr",   bus.WriteAddress,      c_base);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},     64'(bus.WriteEnable), 64'd0);
    check({tag, "_addr"},   bus.WriteAddress,     c_base);
    check({tag, "_data"},   64'(bus.WriteData),   64'd0);
    check({tag, "_loaded"}, 64'(bus.LoadedWords), 64'd0);
    check({tag, "_hold"},   64'(bus.CpuHold),     64'd1);
    check({tag, "_done"},   64'(bus.Done),        64'd0);
    check({tag, "_error"},  64'(bus.Error),       64'd0);
    check({tag, "_ready"},  64'(bus.ByteReady),   64'd1);
  endtask

  // Sends one frame built from frame_words and compares against the frame rules
  task automatic run_frame(input logic [15:0] n, input logic [7:0] csum_flip,
                           input int max_gap, input int junk);
    logic [7:0] cs;
    logic [7:0] jb;
    bit         hdr_ok;
    bit         exp_done;
    int         exp_writes;
    got.delete();
    cs = 8'h00;
    for (int j = 0; j < junk; j++) begin
      jb = 8'($urandom);
      if (jb == 8'hA5) jb = 8'h00;
      send_byte(jb, max_gap);
    end
    send_byte(8'hA5, max_gap);
    send_byte(n[7:0], max_gap);
    send_byte(n[15:8], max_gap);
    hdr_ok = (n != 16'd0) && (int'(n) <= c_max_words);
    if (hdr_ok) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int k = 0; k < 4; k++) begin
          send_byte(frame_words[i][8*k +: 8], max_gap);
          cs = cs ^ frame_words[i][8*k +: 8];
        end
      end
      send_byte(cs ^ csum_flip, max_gap);
    end
    idle(3);
    exp_writes = hdr_ok ? int'(n) : 0;
    exp_done   = hdr_ok && (csum_flip == 8'h00);
    check("write_count", 64'(got.size()), 64'(exp_writes));
    for (int i = 0; i < exp_writes && i < got.size(); i++) begin
      check("write_addr", got[i][95:32], c_base + 64'(4 * i));
      check("write_data", 64'(got[i][31:0]), 64'(frame_words[i]));
    end
    check("done",   64'(bus.Done),        64'(exp_done));
    check("error",  64'(bus.Error),       64'(!exp_done));
    check("hold",   64'(bus.CpuHold),     64'(!exp_done));
    check("ready",  64'(bus.ByteReady),   64'd0);
    check("loaded", 64'(bus.LoadedWords), 64'(exp_writes));
    pulse_start();
  endtask

  initial begin
    bus.ByteData  = 8'h00;
    bus.ByteValid = 1'b0;
    bus.Start     = 1'b0;
    nReset        = 1'b1;
    #2 nReset = 1'b0;
    #3 check_reset_values("reset");
    @(negedge CLK);
    nReset = 1'b1;

    // Single word, back-to-back bytes
    frame_words = '{32'hF84003E9};
    run_frame(16'd1, 8'h00, 0, 0);

    // Two words with random valid gaps
    frame_words = '{32'hF84003E9, 32'hF84083EA};
    run_frame(16'd2, 8'h00, 3, 0);

    // Same frame with checksum 84 instead of 83
    run_frame(16'd2, 8'h07, 2, 0);

    // Junk ahead of the sync byte
    frame_words = '{32'hF84003E9};
    got.delete();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    run_frame(16'd1, 8'h00, 0, 0);

    // Rejected counts
    run_frame(16'd0, 8'h00, 1, 0);
    run_frame(16'd1025, 8'h00, 1, 0);

    // Largest accepted count
    frame_words.delete();
    for (int i = 0; i < 1024; i++) frame_words.push_back($urandom);
    run_frame(16'd1024, 8'h00, 0, 0);

    // Random frames
    for (int r = 0; r < 6; r++) begin
      int unsigned n;
      logic [7:0]  flip;
      n = $urandom_range(1, 8);
      frame_words.delete();
      for (int i = 0; i < int'(n); i++) frame_words.push_back($urandom);
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(16'(n), flip, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of word 1
    frame_words = '{32'h11223344, 32'h55667788};
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(frame_words[0][8*k +: 8], 0);
    send_byte(8'h88, 0);
    send_byte(8'h77, 0);
    #2 nReset = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge CLK);
    bus.ByteValid = 1'b0;
    nReset = 1'b1;
    frame_words = '{32'hF84003E9, 32'hF84083EA};
    run_frame(16'd2, 8'h00, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
